// File: rtl/riscv_single_top.sv
// Single-cycle RV32I subset core: lw, sw, beq, jal, I-type and R-type ALU ops.
// Fetch, decode, execute, memory access and writeback complete in one clock.
// Instruction and data memories are 64-word arrays; the register file and the
// memories are never cleared, so their contents survive reset.

package riscv_single_pkg;
    typedef enum logic [1:0] {
        IMM_I = 2'd0,
        IMM_S = 2'd1,
        IMM_B = 2'd2,
        IMM_J = 2'd3
    } imm_src_e;

    typedef enum logic [3:0] {
        ALU_ADD = 4'd0,
        ALU_SUB = 4'd1,
        ALU_AND = 4'd2,
        ALU_OR  = 4'd3,
        ALU_XOR = 4'd4,
        ALU_SLT = 4'd5,
        ALU_SLL = 4'd6,
        ALU_SRL = 4'd7,
        ALU_SRA = 4'd8
    } alu_op_e;

    typedef enum logic {
        SRC_REG = 1'b0,
        SRC_IMM = 1'b1
    } alu_src_e;

    typedef enum logic [1:0] {
        RES_ALU = 2'd0,
        RES_MEM = 2'd1,
        RES_PC4 = 2'd2
    } res_src_e;

    typedef enum logic {
        PC_PLUS4  = 1'b0,
        PC_TARGET = 1'b1
    } pc_src_e;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_IALU   = 7'b0010011;
    localparam logic [6:0] OP_RALU   = 7'b0110011;
endpackage

// Word-addressed RAM with combinational read and clocked write; no reset.
module word_ram #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);
    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] _mem [0:DEPTH-1];

    // Store one word on the rising edge when enabled.
    always_ff @(posedge clk) begin
        if (we) begin
            _mem[addr] <= wdata;
        end
    end

    assign rdata = _mem[addr];
endmodule

// Instruction memory: a read-only wrapper around a word RAM whose write port is tied off.
module imem (
    input  logic        clk,
    input  logic [5:0]  addr,
    output logic [31:0] data
);
    word_ram #(.DATA_W(32), .ADDR_W(6)) _mem (
        .clk   (clk),
        .we    (1'b0),
        .addr  (addr),
        .wdata (32'd0),
        .rdata (data)
    );
endmodule

// 32x32 register file: two combinational read ports, one clocked write port; x0 is hardwired to zero.
module regfile (
    input  logic        clk,
    input  logic        we,
    input  logic [4:0]  ra1,
    input  logic [4:0]  ra2,
    input  logic [4:0]  wa,
    input  logic [31:0] wd,
    output logic [31:0] rd1,
    output logic [31:0] rd2
);
    logic [31:0] _reg [0:31];

    // Write the destination register; writes aimed at x0 are dropped.
    always_ff @(posedge clk) begin
        if (we && (wa != 5'd0)) begin
            _reg[wa] <= wd;
        end
    end

    assign rd1 = (ra1 == 5'd0) ? 32'd0 : _reg[ra1];
    assign rd2 = (ra2 == 5'd0) ? 32'd0 : _reg[ra2];
endmodule

// Main decoder: maps opcode/funct fields to datapath controls.
module ctrl
    import riscv_single_pkg::*;
(
    input  logic       [6:0] opcode,
    input  logic       [2:0] funct3,
    input  logic             funct7_5,
    input  logic             zero,
    output logic             reg_we,
    output logic             mem_we,
    output imm_src_e         imm_src,
    output alu_op_e          alu_ctrl,
    output alu_src_e         alu_src,
    output res_src_e         res_src,
    output pc_src_e          pc_src
);
    logic is_branch;
    logic is_jump;

    // funct3 picks the ALU op; sub_en only matters for R-type add/sub, arith for shifts.
    function automatic alu_op_e alu_decode(input logic [2:0] f3, input logic sub_en, input logic arith);
        alu_op_e op;
        case (f3)
            3'b000:  op = sub_en ? ALU_SUB : ALU_ADD;
            3'b001:  op = ALU_SLL;
            3'b010:  op = ALU_SLT;
            3'b100:  op = ALU_XOR;
            3'b101:  op = arith ? ALU_SRA : ALU_SRL;
            3'b110:  op = ALU_OR;
            3'b111:  op = ALU_AND;
            default: op = ALU_ADD;
        endcase
        return op;
    endfunction

    // Decode controls; unknown opcodes fall through to a no-write, pc+4 default.
    always_comb begin
        reg_we    = 1'b0;
        mem_we    = 1'b0;
        imm_src   = IMM_I;
        alu_ctrl  = ALU_ADD;
        alu_src   = SRC_REG;
        res_src   = RES_ALU;
        is_branch = 1'b0;
        is_jump   = 1'b0;
        case (opcode)
            OP_LOAD: begin
                reg_we  = 1'b1;
                alu_src = SRC_IMM;
                res_src = RES_MEM;
            end
            OP_STORE: begin
                mem_we  = 1'b1;
                imm_src = IMM_S;
                alu_src = SRC_IMM;
            end
            OP_BRANCH: begin
                imm_src   = IMM_B;
                alu_ctrl  = ALU_SUB;
                is_branch = 1'b1;
            end
            OP_JAL: begin
                reg_we  = 1'b1;
                imm_src = IMM_J;
                res_src = RES_PC4;
                is_jump = 1'b1;
            end
            OP_IALU: begin
                reg_we   = 1'b1;
                alu_src  = SRC_IMM;
                alu_ctrl = alu_decode(funct3, 1'b0, funct7_5);
            end
            OP_RALU: begin
                reg_we   = 1'b1;
                alu_ctrl = alu_decode(funct3, funct7_5, funct7_5);
            end
            default: ;
        endcase
    end

    // Kept apart from the decode block so the zero flag does not loop back through it.
    assign pc_src = (is_jump || (is_branch && zero)) ? PC_TARGET : PC_PLUS4;
endmodule

// Datapath: pc register, register file, immediate generation, ALU and writeback mux.
module datapath
    import riscv_single_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic [31:7]  ifield,
    input  logic         reg_we,
    input  imm_src_e     imm_src,
    input  alu_op_e      alu_ctrl,
    input  alu_src_e     alu_src,
    input  res_src_e     res_src,
    input  pc_src_e      pc_src,
    input  logic [31:0]  mem_rd_data,
    output logic [31:0]  pc,
    output logic [31:0]  alu_out,
    output logic [31:0]  mem_wd_data,
    output logic         zero
);
    logic [31:0] imm;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic [31:0] pc_plus4;
    logic [31:0] pc_target;
    logic [31:0] pc_next;
    logic [31:0] result;

    // Sign-extended immediate; B and J offsets always have bit 0 clear.
    function automatic logic [31:0] imm_ext(input imm_src_e sel, input logic [31:7] f);
        logic [31:0] v;
        case (sel)
            IMM_I:   v = {{20{f[31]}}, f[31:20]};
            IMM_S:   v = {{20{f[31]}}, f[31:25], f[11:7]};
            IMM_B:   v = {{19{f[31]}}, f[31], f[7], f[30:25], f[11:8], 1'b0};
            IMM_J:   v = {{11{f[31]}}, f[31], f[19:12], f[20], f[30:21], 1'b0};
            default: v = 32'd0;
        endcase
        return v;
    endfunction

    // 32-bit wraparound ALU; SLT and SRA treat operands as signed, shifts use b[4:0].
    function automatic logic [31:0] alu(input alu_op_e op, input logic [31:0] a, input logic [31:0] b);
        logic signed [31:0] sa;
        logic signed [31:0] sb;
        logic [31:0]        r;
        sa = a;
        sb = b;
        case (op)
            ALU_ADD: r = a + b;
            ALU_SUB: r = a - b;
            ALU_AND: r = a & b;
            ALU_OR:  r = a | b;
            ALU_XOR: r = a ^ b;
            ALU_SLT: r = {31'd0, (sa < sb)};
            ALU_SLL: r = a << b[4:0];
            ALU_SRL: r = a >> b[4:0];
            ALU_SRA: r = $unsigned(sa >>> b[4:0]);
            default: r = a + b;
        endcase
        return r;
    endfunction

    // Register writes are held off while reset is asserted.
    regfile rf (
        .clk (clk),
        .we  (reg_we & rst),
        .ra1 (ifield[19:15]),
        .ra2 (ifield[24:20]),
        .wa  (ifield[11:7]),
        .wd  (result),
        .rd1 (src_a),
        .rd2 (mem_wd_data)
    );

    assign imm       = imm_ext(imm_src, ifield);
    assign src_b     = (alu_src == SRC_IMM) ? imm : mem_wd_data;
    assign alu_out   = alu(alu_ctrl, src_a, src_b);
    assign zero      = (alu_out == 32'd0);
    assign pc_plus4  = pc + 32'd4;
    assign pc_target = pc + imm;
    assign pc_next   = (pc_src == PC_TARGET) ? pc_target : pc_plus4;

    // Select the value written back to rd.
    always_comb begin
        result = alu_out;
        case (res_src)
            RES_ALU: result = alu_out;
            RES_MEM: result = mem_rd_data;
            RES_PC4: result = pc_plus4;
            default: result = alu_out;
        endcase
    end

    // Program counter: cleared immediately by reset, otherwise advanced every clock.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc <= 32'd0;
        end else begin
            pc <= pc_next;
        end
    end
endmodule

// Top level: controller, datapath and the two memories.
module riscv_single_top
    import riscv_single_pkg::*;
(
    output logic        reg_we,
    output logic        mem_we,
    output imm_src_e    imm_src,
    output alu_op_e     alu_ctrl,
    output alu_src_e    alu_src,
    output res_src_e    res_src,
    output pc_src_e     pc_src,
    output logic [31:0] instr,
    output logic [31:0] alu_out,
    output logic [31:0] mem_rd_data,
    output logic [31:0] mem_wd_data,
    output logic [31:0] pc,
    input  logic        rst,
    input  logic        clk
);
    localparam int DATA_W = 32;

    logic zero;

    ctrl cu (
        .opcode   (instr[6:0]),
        .funct3   (instr[14:12]),
        .funct7_5 (instr[30]),
        .zero     (zero),
        .reg_we   (reg_we),
        .mem_we   (mem_we),
        .imm_src  (imm_src),
        .alu_ctrl (alu_ctrl),
        .alu_src  (alu_src),
        .res_src  (res_src),
        .pc_src   (pc_src)
    );

    datapath dp (
        .clk         (clk),
        .rst         (rst),
        .ifield      (instr[31:7]),
        .reg_we      (reg_we),
        .imm_src     (imm_src),
        .alu_ctrl    (alu_ctrl),
        .alu_src     (alu_src),
        .res_src     (res_src),
        .pc_src      (pc_src),
        .mem_rd_data (mem_rd_data),
        .pc          (pc),
        .alu_out     (alu_out),
        .mem_wd_data (mem_wd_data),
        .zero        (zero)
    );

    imem instr_mem (
        .clk  (clk),
        .addr (pc[7:2]),
        .data (instr)
    );

    // Stores are held off while reset is asserted.
    word_ram #(.DATA_W(DATA_W), .ADDR_W(6)) data_mem (
        .clk   (clk),
        .we    (mem_we & rst),
        .addr  (alu_out[7:2]),
        .wdata (mem_wd_data),
        .rdata (mem_rd_data)
    );
endmodule

// File: tb/tb_riscv_single_top.sv
// Directed bench for riscv_single_top: expectations are queued before each
// clock step and popped/compared once the DUT has produced its result.
module tb_riscv_single_top;
    import riscv_single_pkg::*;

    localparam int K_REG = 0;
    localparam int K_MEM = 1;
    localparam int K_PC  = 2;
    localparam int K_SIG = 3;

    localparam int S_REG_WE   = 0;
    localparam int S_MEM_WE   = 1;
    localparam int S_IMM_SRC  = 2;
    localparam int S_ALU_CTRL = 3;
    localparam int S_ALU_SRC  = 4;
    localparam int S_RES_SRC  = 5;
    localparam int S_PC_SRC   = 6;
    localparam int S_INSTR    = 7;
    localparam int S_ALU_OUT  = 8;
    localparam int S_MEM_RD   = 9;
    localparam int S_MEM_WD   = 10;

    logic        clk;
    logic        rst;
    logic        reg_we;
    logic        mem_we;
    imm_src_e    imm_src;
    alu_op_e     alu_ctrl;
    alu_src_e    alu_src;
    res_src_e    res_src;
    pc_src_e     pc_src;
    logic [31:0] instr;
    logic [31:0] alu_out;
    logic [31:0] mem_rd_data;
    logic [31:0] mem_wd_data;
    logic [31:0] pc;

    riscv_single_top dut (
        .reg_we      (reg_we),
        .mem_we      (mem_we),
        .imm_src     (imm_src),
        .alu_ctrl    (alu_ctrl),
        .alu_src     (alu_src),
        .res_src     (res_src),
        .pc_src      (pc_src),
        .instr       (instr),
        .alu_out     (alu_out),
        .mem_rd_data (mem_rd_data),
        .mem_wd_data (mem_wd_data),
        .pc          (pc),
        .rst         (rst),
        .clk         (clk)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    typedef struct {
        string       tag;
        int          kind;
        int          idx;
        logic [31:0] val;
    } exp_t;

    exp_t sb[$];
    int checks   = 0;
    int failures = 0;

    // Program A: addi chain on x0/x4/x5.
    logic [31:0] prog_a [0:9] = '{
        32'h01420013, 32'h00a00213, 32'h01400293, 32'hff620213, 32'hff620213,
        32'h00a20213, 32'h00a20213, 32'h00028213, 32'h00000213, 32'h01428213
    };
    int          p1_rd  [0:9] = '{0, 4, 5, 4, 4, 4, 4, 4, 4, 4};
    logic [31:0] p1_val [0:9] = '{
        32'd0, 32'd10, 32'd20, 32'd0, 32'hfffffff6,
        32'd0, 32'd10, 32'd20, 32'd0, 32'd40
    };

    // Program B: sw, lw, beq taken, filler, jal, fillers, beq not taken, ALU ops, unknown opcode.
    logic [31:0] prog_b [0:21] = '{
        32'h00502423, 32'h00802303, 32'h00420463, 32'h00000213, 32'h00c000ef,
        32'h00000213, 32'h00000213, 32'h00520463, 32'hff600413, 32'h00a00493,
        32'h009423b3, 32'h0084a533, 32'h408485b3, 32'h40940633, 32'h008406b3,
        32'h40245793, 32'h01c45813, 32'h00349893, 32'h00947933, 32'h009469b3,
        32'h00944a33, 32'hffffffff
    };
    // Results of words 8..20 of program B.
    int          p2_rd  [0:12] = '{8, 9, 7, 10, 11, 12, 13, 15, 16, 17, 18, 19, 20};
    logic [31:0] p2_val [0:12] = '{
        32'hfffffff6, 32'h0000000a, 32'h00000001, 32'h00000000, 32'h00000014,
        32'hffffffec, 32'hffffffec, 32'hfffffffd, 32'h0000000f, 32'h00000050,
        32'h00000002, 32'hfffffffe, 32'hfffffffc
    };

    function automatic logic [31:0] observe(input int kind, input int idx);
        logic [31:0] r;
        r = 32'hdeadbeef;
        case (kind)
            K_REG: r = dut.dp.rf._reg[idx];
            K_MEM: r = dut.data_mem._mem[idx];
            K_PC:  r = pc;
            K_SIG: begin
                case (idx)
                    S_REG_WE:   r = {31'd0, reg_we};
                    S_MEM_WE:   r = {31'd0, mem_we};
                    S_IMM_SRC:  r = {30'd0, imm_src};
                    S_ALU_CTRL: r = {28'd0, alu_ctrl};
                    S_ALU_SRC:  r = {31'd0, alu_src};
                    S_RES_SRC:  r = {30'd0, res_src};
                    S_PC_SRC:   r = {31'd0, pc_src};
                    S_INSTR:    r = instr;
                    S_ALU_OUT:  r = alu_out;
                    S_MEM_RD:   r = mem_rd_data;
                    S_MEM_WD:   r = mem_wd_data;
                    default:    r = 32'hdeadbeef;
                endcase
            end
            default: r = 32'hdeadbeef;
        endcase
        return r;
    endfunction

    task automatic expect_val(input string tag, input int kind, input int idx, input logic [31:0] val);
        exp_t e;
        e.tag  = tag;
        e.kind = kind;
        e.idx  = idx;
        e.val  = val;
        sb.push_back(e);
    endtask

    task automatic drain();
        exp_t        e;
        logic [31:0] obs;
        while (sb.size() != 0) begin
            e   = sb.pop_front();
            obs = observe(e.kind, e.idx);
            checks++;
            assert (obs === e.val)
            else begin
                failures++;
                $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.val);
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic exec_reg(input string tag, input int rd, input logic [31:0] val, input logic [31:0] next_pc);
        expect_val({tag, "_rd"}, K_REG, rd, val);
        expect_val({tag, "_pc"}, K_PC, 0, next_pc);
        step();
        drain();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1;
        for (int i = 0; i < 64; i++) begin
            dut.instr_mem._mem._mem[i] = 32'd0;
            dut.data_mem._mem[i]       = 32'd0;
        end
        for (int i = 0; i < 32; i++) dut.dp.rf._reg[i] = 32'd0;
        for (int i = 0; i < 10; i++) dut.instr_mem._mem._mem[i] = prog_a[i];

        // Reset takes effect without a clock edge.
        #3 rst = 1'b0;
        #1;
        expect_val("rst_async_pc", K_PC, 0, 32'd0);
        drain();
        step();
        step();
        expect_val("rst_hold_pc", K_PC, 0, 32'd0);
        expect_val("fetch_w0", K_SIG, S_INSTR, 32'h01420013);
        drain();

        @(negedge clk);
        rst = 1'b1;
        #1;
        expect_val("addi_reg_we", K_SIG, S_REG_WE, 32'd1);
        expect_val("addi_alu_src", K_SIG, S_ALU_SRC, 32'd1);
        expect_val("addi_imm_src", K_SIG, S_IMM_SRC, 32'd0);
        drain();
        for (int k = 0; k < 10; k++) begin
            exec_reg($sformatf("p1_%0d", k), p1_rd[k], p1_val[k], 32'(4 * (k + 1)));
        end

        // Program B loaded under reset; the sw at word 0 must not store while held.
        @(negedge clk);
        #3 rst = 1'b0;
        #1;
        expect_val("p2_rst_pc", K_PC, 0, 32'd0);
        drain();
        for (int i = 0; i < 22; i++) dut.instr_mem._mem._mem[i] = prog_b[i];
        step();
        step();
        expect_val("rst_sw_suppressed", K_MEM, 2, 32'd0);
        expect_val("rst_hold_pc2", K_PC, 0, 32'd0);
        drain();

        @(negedge clk);
        rst = 1'b1;
        #1;
        expect_val("sw_mem_we", K_SIG, S_MEM_WE, 32'd1);
        expect_val("sw_reg_we", K_SIG, S_REG_WE, 32'd0);
        expect_val("sw_imm_src", K_SIG, S_IMM_SRC, 32'd1);
        expect_val("sw_alu_out", K_SIG, S_ALU_OUT, 32'd8);
        expect_val("sw_wd", K_SIG, S_MEM_WD, 32'd20);
        drain();
        expect_val("sw_word2", K_MEM, 2, 32'd20);
        expect_val("sw_pc", K_PC, 0, 32'd4);
        step();
        drain();

        expect_val("lw_mem_we", K_SIG, S_MEM_WE, 32'd0);
        expect_val("lw_res_src", K_SIG, S_RES_SRC, 32'd1);
        expect_val("lw_rd_data", K_SIG, S_MEM_RD, 32'd20);
        drain();
        exec_reg("lw_x6", 6, 32'd20, 32'h8);

        expect_val("beq_t_pc_src", K_SIG, S_PC_SRC, 32'd1);
        expect_val("beq_alu_ctrl", K_SIG, S_ALU_CTRL, 32'd1);
        expect_val("beq_imm_src", K_SIG, S_IMM_SRC, 32'd2);
        drain();
        exec_reg("beq_taken", 4, 32'd40, 32'h10);

        expect_val("jal_pc_src", K_SIG, S_PC_SRC, 32'd1);
        expect_val("jal_res_src", K_SIG, S_RES_SRC, 32'd2);
        expect_val("jal_imm_src", K_SIG, S_IMM_SRC, 32'd3);
        drain();
        exec_reg("jal_x1", 1, 32'h14, 32'h1c);

        expect_val("beq_nt_pc_src", K_SIG, S_PC_SRC, 32'd0);
        drain();
        exec_reg("beq_not_taken", 4, 32'd40, 32'h20);

        for (int k = 0; k < 13; k++) begin
            if (k == 2) begin
                expect_val("slt_alu_ctrl", K_SIG, S_ALU_CTRL, 32'd5);
                expect_val("slt_alu_out", K_SIG, S_ALU_OUT, 32'd1);
                drain();
            end
            if (k == 7) begin
                expect_val("srai_alu_ctrl", K_SIG, S_ALU_CTRL, 32'd8);
                drain();
            end
            exec_reg($sformatf("alu_%0d", k), p2_rd[k], p2_val[k], 32'h20 + 32'(4 * (k + 1)));
        end

        expect_val("unk_reg_we", K_SIG, S_REG_WE, 32'd0);
        expect_val("unk_mem_we", K_SIG, S_MEM_WE, 32'd0);
        expect_val("unk_pc_src", K_SIG, S_PC_SRC, 32'd0);
        drain();
        exec_reg("unk_x31", 31, 32'd0, 32'h58);

        // Mid-program reset away from an edge: pc clears, registers persist.
        @(negedge clk);
        #5 rst = 1'b0;
        #1;
        expect_val("mid_rst_pc", K_PC, 0, 32'd0);
        expect_val("mid_rst_x4", K_REG, 4, 32'd40);
        expect_val("mid_rst_x6", K_REG, 6, 32'd20);
        expect_val("mid_rst_x7", K_REG, 7, 32'd1);
        drain();
        dut.instr_mem._mem._mem[0] = 32'h05500a93;
        step();
        step();
        expect_val("rst_reg_suppressed", K_REG, 21, 32'd0);
        expect_val("mid_rst_hold_pc", K_PC, 0, 32'd0);
        drain();

        @(negedge clk);
        rst = 1'b1;
        #1;
        expect_val("restart_fetch", K_SIG, S_INSTR, 32'h05500a93);
        drain();
        exec_reg("restart_x21", 21, 32'h55, 32'h4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
